// File: rtl/binary_16b_counter_free_running.sv
// Purpose : free-running modulo-(max_count+1) counter that pulses max_tick at the terminal value
//           (baud / oversampling tick source for the UART path).
// Latency : max_tick is a same-cycle combinational decode of the registered count and live max_count.
// Backpr. : none; the counter never stalls, and a missed tick is not replayed.
//
// Ports:
//   clk        in  1  single clock, rising-edge state updates
//   reset      in  1  synchronous, active-low (0 = clear count)
//   max_count  in  N  terminal count; may change any cycle
//   max_tick   out 1  high while count == max_count and reset is high
module binary_16b_counter_free_running #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] max_count,
  output logic [0:0]   max_tick
);

  logic [N-1:0] count;
  logic         at_max;

  // Equality only, so lowering max_count below the running count does not
  // wrap early. The counter runs on to all-ones and rolls over naturally.
  assign at_max = (count == max_count);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (at_max) begin
      count <= '0;
    end else begin
      count <= count + N'(1);
    end
  end

  // Gate with reset so that no tick leaks out during the reset cycle.
  assign max_tick = reset & at_max;

endmodule

// File: tb/tb_binary_16b_counter_free_running.sv
module tb_binary_16b_counter_free_running;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] max_count;
  logic        max_tick;

  // 50 MHz: 20 ns period
  always #10 clk = ~clk;

  binary_16b_counter_free_running #(.N(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .max_count (max_count),
    .max_tick  (max_tick)
  );

  // Per-cycle expected tick, pushed by the stimulus and consumed by the monitor.
  typedef struct {
    logic tick;
    int   phase;
    int   cyc;
  } exp_t;

  // Whole-run checks, posted by the stimulus and evaluated by the monitor
  // so that only one process steps the counters.
  typedef struct {
    string  name;
    bit     ok;
    longint got;
    longint want;
  } aux_t;

  exp_t exp_q[$];
  aux_t aux_q[$];

  int  n_checks = 0;
  int  n_pass = 0;
  int  obs_ticks = 0;
  time last_tick_t = 0;
  time prev_tick_t = 0;
  int  phase_id = 0;

  exp_t mon_e;
  aux_t mon_a;

  // Monitor: samples on the falling edge, midway between the rising edges.
  always @(negedge clk) begin
    if (max_tick === 1'b1) begin
      obs_ticks   <= obs_ticks + 1;
      prev_tick_t <= last_tick_t;
      last_tick_t <= $time;
    end
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      n_checks = n_checks + 1;
      if (max_tick === mon_e.tick) begin
        n_pass = n_pass + 1;
      end else begin
        $display("FAIL max_tick phase %0d cyc %0d: got %b, want %b",
                 mon_e.phase, mon_e.cyc, max_tick, mon_e.tick);
      end
    end
    while (aux_q.size() > 0) begin
      mon_a = aux_q.pop_front();
      n_checks = n_checks + 1;
      if (mon_a.ok) begin
        n_pass = n_pass + 1;
      end else begin
        $display("FAIL %s: got %0d, want %0d", mon_a.name, mon_a.got, mon_a.want);
      end
    end
  end

  // One clock: inputs are already set for this cycle; record the expected
  // tick, then move to 1 ns after the next rising edge.
  task automatic step(input logic tick, input int cyc);
    exp_q.push_back('{tick: tick, phase: phase_id, cyc: cyc});
    @(posedge clk);
    #1;
  endtask

  task automatic post(input string name, input bit ok, input longint got, input longint want);
    aux_q.push_back('{name: name, ok: ok, got: got, want: want});
  endtask

  int t0;

  initial begin
    reset     = 1'b0;
    max_count = 16'd0;
    @(posedge clk);
    #1;

    // Phase 1: reset held for 5 cycles with max_count = 0, then a tick every cycle.
    phase_id = 1;
    for (int c = 0; c < 5; c++) step(1'b0, c);
    reset = 1'b1;
    for (int c = 0; c < 6; c++) step(1'b1, c);

    // Phase 2: small modulus, M = 3 -> 0,0,0,1 repeating from cycle 0.
    phase_id = 2;
    reset = 1'b0;
    max_count = 16'd3;
    step(1'b0, -1);
    reset = 1'b1;
    for (int c = 0; c < 12; c++) step((c % 4) == 3, c);

    // Phase 3: baud rate, M = 163 -> tick every 164 cycles (3280 ns).
    // Window of 2 x 26041.7 ns = 2604 cycles should hold 16 +/- 1 ticks.
    phase_id = 3;
    reset = 1'b0;
    max_count = 16'd163;
    step(1'b0, -1);
    reset = 1'b1;
    t0 = obs_ticks;
    for (int c = 0; c < 2604; c++) step((c % 164) == 163, c);
    post("baud_tick_count", ((obs_ticks - t0) >= 15) && ((obs_ticks - t0) <= 17),
         longint'(obs_ticks - t0), 64'd16);
    post("baud_tick_spacing_ns", (last_tick_t - prev_tick_t) == 3280,
         longint'(last_tick_t - prev_tick_t), 64'd3280);

    // Phase 4: reset for one cycle at count = 80; next tick 163 cycles after release.
    phase_id = 4;
    reset = 1'b0;
    step(1'b0, -1);
    reset = 1'b1;
    for (int c = 0; c < 80; c++) step(1'b0, c);
    reset = 1'b0;
    step(1'b0, 80);
    reset = 1'b1;
    for (int c = 0; c <= 170; c++) step(c == 163, c);

    // Phase 5: lower max_count from 100 to 10 at count = 50. The count must
    // keep climbing with no tick. Near the top, raise max_count to 65535:
    // the period extends, one tick lands at 65535, and the following
    // rollover cycle has no tick. Then return to M = 10 and period 11.
    phase_id = 5;
    reset = 1'b0;
    max_count = 16'd100;
    step(1'b0, -1);
    reset = 1'b1;
    for (int c = 0; c < 50; c++) step(1'b0, c);
    max_count = 16'd10;
    for (int c = 50; c < 65500; c++) step(1'b0, c);
    max_count = 16'd65535;
    for (int c = 65500; c < 65535; c++) step(1'b0, c);
    step(1'b1, 65535);
    step(1'b0, 0);
    step(1'b0, 1);
    max_count = 16'd10;
    for (int c = 2; c < 10; c++) step(1'b0, c);
    step(1'b1, 10);
    for (int c = 0; c < 10; c++) step(1'b0, c);
    step(1'b1, 10);

    // Every queued expectation must have been consumed by the monitor.
    post("scoreboard_drained", exp_q.size() == 0, longint'(exp_q.size()), 64'd0);
    @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
